// File: rtl/arinc429_rx_buffer.sv
// ARINC429 receive buffer: label filter, word FIFO, Avalon-MM control/status, level IRQ.
// Optional feature macro: ARINC429_RX_TIMESTAMP_EN (per-entry 32-bit timestamp, readable at addr 5).
module arinc429_rx_buffer #(
  parameter string       DEVICE_FAMILY = "Cyclone V",
  parameter int unsigned FIFO_SIZE     = 4096
) (
  input  logic        i_avs_clk,
  input  logic        i_avs_rst_n,
  input  logic        i_snk_rx_valid,
  input  logic [31:0] i_snk_rx_data,
  output logic        o_snk_rx_ready,
  input  logic        i_rx_par_err,
  input  logic [2:0]  i_avs_address,
  input  logic        i_avs_read,
  input  logic        i_avs_write,
  input  logic [31:0] i_avs_writedata,
  output logic [31:0] o_avs_readdata,
  output logic        o_irq
);

  localparam int unsigned AW     = $clog2(FIFO_SIZE);
  localparam int unsigned LVL_W  = 17;
  localparam int unsigned DATA_W = 32;
`ifdef ARINC429_RX_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = 2 * DATA_W + 1;
`else
  localparam int unsigned ENTRY_W = DATA_W + 1;
`endif

  // Reject unsupported depths or an empty family string at elaboration.
  if (FIFO_SIZE < 16 || FIFO_SIZE > 65536 || (FIFO_SIZE & (FIFO_SIZE - 1)) != 0
      || DEVICE_FAMILY == "") begin : g_bad_param
    $error("arinc429_rx_buffer: illegal parameter value");
  end

  logic               en, filt, drop_pe, irq_en;
  logic [2:0]         lbl_idx;
  logic [31:0]        lbl_tbl [8];
  logic               ovf, unf, pe_sticky, hpe;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [ENTRY_W-1:0] mem [FIFO_SIZE];
  logic [ENTRY_W-1:0] head, entry;
  logic [31:0]        rd_mux, status, tstamp_rd;
  logic               take, lbl_hit, accept, full, empty, push, pop;
  logic               data_rd, ctrl_wr, flush, clr_sticky;
  logic               ovf_set, unf_set, pe_set;
  logic               unused_wdata;

  assign unused_wdata = ^{i_avs_writedata[31:10], i_avs_writedata[7:4]};

  assign take       = i_snk_rx_valid & o_snk_rx_ready;
  assign lbl_hit    = lbl_tbl[i_snk_rx_data[7:5]][i_snk_rx_data[4:0]];
  assign accept     = take & en & (~filt | lbl_hit) & (~drop_pe | ~i_rx_par_err);
  assign full       = (level == LVL_W'(FIFO_SIZE));
  assign empty      = (level == '0);
  assign data_rd    = i_avs_read & (i_avs_address == 3'd0);
  assign ctrl_wr    = i_avs_write & (i_avs_address == 3'd2);
  assign flush      = ctrl_wr & i_avs_writedata[8];
  assign clr_sticky = ctrl_wr & i_avs_writedata[9];
  assign pop        = data_rd & ~empty;
  // Flush discards a coincident push; a full FIFO still accepts when a pop frees a slot.
  assign push       = accept & ~flush & (~full | pop);
  assign ovf_set    = accept & ~flush & full & ~pop;
  assign unf_set    = data_rd & empty;
  assign pe_set     = accept & i_rx_par_err;
  assign head       = mem[rd_ptr];
  assign status     = {9'd0, hpe, pe_sticky, unf, ovf, full, empty, level};

`ifdef ARINC429_RX_TIMESTAMP_EN
  logic [31:0] ts_cnt, tstamp;

  assign entry     = {ts_cnt, i_rx_par_err, i_snk_rx_data};
  assign tstamp_rd = tstamp;

  // Free-running timestamp counter and stamp of the most recently popped entry.
  always_ff @(posedge i_avs_clk or negedge i_avs_rst_n) begin
    if (!i_avs_rst_n) begin
      ts_cnt <= '0;
      tstamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (pop) tstamp <= head[64:33];
    end
  end
`else
  assign entry     = {i_rx_par_err, i_snk_rx_data};
  assign tstamp_rd = '0;
`endif

  // FIFO storage; contents are never visible while empty, so no reset needed.
  always_ff @(posedge i_avs_clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // FIFO pointers and fill level.
  always_ff @(posedge i_avs_clk or negedge i_avs_rst_n) begin
    if (!i_avs_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Control, label table, sticky flags and head parity latch.
  always_ff @(posedge i_avs_clk or negedge i_avs_rst_n) begin
    if (!i_avs_rst_n) begin
      en        <= 1'b0;
      filt      <= 1'b0;
      drop_pe   <= 1'b0;
      irq_en    <= 1'b0;
      lbl_idx   <= '0;
      for (int i = 0; i < 8; i++) lbl_tbl[i] <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      pe_sticky <= 1'b0;
      hpe       <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en      <= i_avs_writedata[0];
        filt    <= i_avs_writedata[1];
        drop_pe <= i_avs_writedata[2];
        irq_en  <= i_avs_writedata[3];
      end
      if (i_avs_write && i_avs_address == 3'd3) lbl_idx <= i_avs_writedata[2:0];
      if (i_avs_write && i_avs_address == 3'd4) lbl_tbl[lbl_idx] <= i_avs_writedata;
      ovf       <= ovf_set | (ovf & ~clr_sticky);
      unf       <= unf_set | (unf & ~clr_sticky);
      pe_sticky <= pe_set | (pe_sticky & ~clr_sticky);
      if (pop) hpe <= head[32];
    end
  end

  // Register-map read mux.
  always_comb begin
    rd_mux = '0;
    case (i_avs_address)
      3'd0:    rd_mux = empty ? 32'hFACE_DEAD : head[31:0];
      3'd1:    rd_mux = status;
      3'd2:    rd_mux = {28'd0, irq_en, drop_pe, filt, en};
      3'd3:    rd_mux = {29'd0, lbl_idx};
      3'd4:    rd_mux = lbl_tbl[lbl_idx];
      3'd5:    rd_mux = tstamp_rd;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, sink ready and interrupt.
  always_ff @(posedge i_avs_clk or negedge i_avs_rst_n) begin
    if (!i_avs_rst_n) begin
      o_avs_readdata <= '0;
      o_snk_rx_ready <= 1'b0;
      o_irq          <= 1'b0;
    end else begin
      if (i_avs_read) o_avs_readdata <= rd_mux;
      o_snk_rx_ready <= 1'b1;
      o_irq          <= irq_en & (~empty | ovf);
    end
  end

endmodule

// File: tb/tb_arinc429_rx_buffer.sv
// Self-checking bench for arinc429_rx_buffer with a scoreboard of expected FIFO entries.
module tb_arinc429_rx_buffer;

  localparam int unsigned FIFO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_ready;
  logic        par_err = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Bench model state
  logic [32:0]  sb[$];
  logic [255:0] m_lbl = '0;
  logic         m_en = 0, m_filt = 0, m_drop = 0;
  logic         m_ovf = 0, m_unf = 0, m_pe = 0, m_hpe = 0;

  arinc429_rx_buffer #(.FIFO_SIZE(FIFO)) dut (
    .i_avs_clk       (clk),
    .i_avs_rst_n     (rst_n),
    .i_snk_rx_valid  (rx_valid),
    .i_snk_rx_data   (rx_data),
    .o_snk_rx_ready  (rx_ready),
    .i_rx_par_err    (par_err),
    .i_avs_address   (address),
    .i_avs_read      (read),
    .i_avs_write     (write),
    .i_avs_writedata (writedata),
    .o_avs_readdata  (readdata),
    .o_irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_status();
    logic [16:0] lvl;
    lvl = 17'(sb.size());
    return {9'd0, m_hpe, m_pe, m_unf, m_ovf, (sb.size() == FIFO), (sb.size() == 0), lvl};
  endfunction

  task automatic model_push(input logic [31:0] w, input logic pe);
    if (m_en && (!m_filt || m_lbl[w[7:0]]) && (!m_drop || !pe)) begin
      if (pe) m_pe = 1'b1;
      if (sb.size() < FIFO) sb.push_back({pe, w});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_pop(output logic [31:0] e);
    logic [32:0] ent;
    if (sb.size() == 0) begin
      m_unf = 1'b1;
      e = 32'hFACE_DEAD;
    end else begin
      ent = sb.pop_front();
      m_hpe = ent[32];
      e = ent[31:0];
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_lbl = '0;
    {m_en, m_filt, m_drop, m_ovf, m_unf, m_pe, m_hpe} = '0;
  endtask

  task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); address = a; writedata = d; write = 1'b1;
    @(negedge clk); write = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); address = a; read = 1'b1;
    @(negedge clk); read = 1'b0; d = readdata;
  endtask

  task automatic send(input logic [31:0] w, input logic pe);
    @(negedge clk); rx_valid = 1'b1; rx_data = w; par_err = pe;
    @(negedge clk); rx_valid = 1'b0; par_err = 1'b0;
    model_push(w, pe);
  endtask

  task automatic set_ctrl(input logic [31:0] v);
    avs_wr(3'd2, v);
    m_en = v[0]; m_filt = v[1]; m_drop = v[2];
    if (v[8]) sb.delete();
    if (v[9]) begin m_ovf = 1'b0; m_unf = 1'b0; m_pe = 1'b0; end
  endtask

  task automatic set_label(input logic [2:0] idx, input logic [31:0] mask);
    avs_wr(3'd3, {29'd0, idx});
    avs_wr(3'd4, mask);
    m_lbl[idx*32 +: 32] = mask;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d, e;
    avs_rd(3'd0, d);
    model_pop(e);
    check(tag, d, e);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    avs_rd(3'd1, d);
    check(tag, d, exp_status());
  endtask

  // Push on a full FIFO while the CPU pops in the same cycle.
  task automatic push_and_pop(input logic [31:0] w);
    logic [31:0] e;
    @(negedge clk); rx_valid = 1'b1; rx_data = w; par_err = 1'b0; address = 3'd0; read = 1'b1;
    @(negedge clk); rx_valid = 1'b0; read = 1'b0;
    model_pop(e);
    model_push(w, 1'b0);
    check("simul_pop", readdata, e);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && !rx_ready; i++) @(negedge clk);
    check("ready_up", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    model_reset();
    rst_n = 1'b1;
    wait_ready();
  endtask

  initial begin
    logic [31:0] d, t1, t2;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    wait_ready();
    check_status("status_rst");
    check("status_rst_c", exp_status(), 32'h0002_0000);

    // Single word, IRQ follows non-empty
    set_ctrl(32'h9);
    send(32'h1234_5678, 1'b0);
    avs_rd(3'd1, d);
    check("t1_level", d, 32'h0000_0001);
    check("t1_irq_on", {31'd0, irq}, 32'd1);
    read_data("t1_data");
    check_status("t1_empty");
    check("t1_irq_off", {31'd0, irq}, 32'd0);

    // Label filtering
    set_ctrl(32'hB);
    set_label(3'd2, 32'h0000_0001);
    avs_rd(3'd4, d);
    check("lbl_mask_rb", d, 32'h0000_0001);
    send(32'hAAAA_BB40, 1'b0);
    send(32'hAAAA_BB41, 1'b0);
    check_status("t2_level");
    read_data("t2_data");

    // Fill, full with simultaneous push/pop, overflow, drain, underflow
    set_ctrl(32'h1);
    for (int i = 0; i < FIFO; i++) send(32'h1000_0000 + 32'(i), 1'b0);
    check_status("t3_full");
    push_and_pop(32'h2000_0000);
    check_status("t3_full_pp");
    send(32'h3000_0000, 1'b0);
    check_status("t3_ovf");
    for (int i = 0; i < FIFO; i++) read_data("t3_drain");
    read_data("t3_underflow");
    check_status("t3_unf");
    set_ctrl(32'h201);
    check_status("t3_clr");

    // Parity error handling
    send(32'hA5A5_A5A5, 1'b1);
    check_status("t4_pe");
    read_data("t4_data");
    check_status("t4_hpe");
    set_ctrl(32'h201);
    check_status("t4_clr");
    set_ctrl(32'h5);
    send(32'h5A5A_5A5A, 1'b1);
    check_status("t4_drop_pe");

    // Flush with words queued
    set_ctrl(32'h1);
    for (int i = 0; i < 5; i++) send(32'h4000_0000 + 32'(i), 1'b0);
    check_status("t5_five");
    set_ctrl(32'h101);
    check_status("t5_flushed");
    avs_rd(3'd2, d);
    check("ctrl_rb", d, 32'h0000_0001);

    // Disabled receiver drops words; unused addresses read 0
    set_ctrl(32'h0);
    send(32'h7777_7777, 1'b0);
    check_status("t6_disabled");
    avs_wr(3'd6, 32'hFFFF_FFFF);
    avs_rd(3'd6, d);
    check("addr6", d, 32'd0);
    avs_rd(3'd2, d);
    check("ctrl_after_a6", d, 32'd0);

`ifdef ARINC429_RX_TIMESTAMP_EN
    set_ctrl(32'h1);
    send(32'h0000_0011, 1'b0);
    repeat (98) @(negedge clk);
    send(32'h0000_0022, 1'b0);
    read_data("ts_data0");
    avs_rd(3'd5, t1);
    read_data("ts_data1");
    avs_rd(3'd5, t2);
    check("ts_delta", t2 - t1, 32'd100);
`else
    avs_rd(3'd5, d);
    check("tstamp_off", d, 32'd0);
`endif

    // Reset mid-operation clears FIFO and label table
    set_ctrl(32'h1);
    set_label(3'd2, 32'hFFFF_0000);
    send(32'h5555_0001, 1'b0);
    send(32'h5555_0002, 1'b0);
    do_reset();
    check_status("t7_status");
    avs_wr(3'd3, 32'd2);
    avs_rd(3'd4, d);
    check("t7_lbl", d, 32'd0);
    read_data("t7_unf");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
